mig_ui_responder: RTL
=====================

# mig_ui_responder

Synthesizable stand-in for the DDR3 MIG user-interface (UI) port, on the memory side of the app_* handshake. It accepts app_cmd/app_addr/app_wdf_* traffic from an initiator FSM and returns app_rdy, app_wdf_rdy and read data from an on-chip 256-bit-wide array. It also emits init_calib_complete. It lets sound-engine masters run, in simulation or on FPGA, without DDR3 pins or calibration.

## Interface
- DEPTH_LOG2, 6: array holds 2^DEPTH_LOG2 words of 256 bits.
- RD_LATENCY, 8: cycles from read-command acceptance to app_rd_data_valid; legal range 2..31.
- CALIB_CYCLES, 64: cycles after reset release before init_calib_complete rises; legal range 1..65535.
- ui_clk  in  1  sole clock; every app_* signal is sampled and driven on its rising edge.
- sys_rst  in  1  reset, asynchronous assert, active-low; deassertion is synchronized internally to ui_clk.
- app_addr  in  29  byte-burst address; word index = app_addr[DEPTH_LOG2+2:3], all other bits ignored.
- app_cmd  in  3  3'b000 write, 3'b001 read; any other code is accepted and has no effect.
- app_en  in  1  command valid.
- app_wdf_data  in  256  write data.
- app_wdf_wren  in  1  write-data valid.
- app_wdf_end  in  1  ignored; expected equal to app_wdf_wren.
- app_wdf_mask  in  32  bit i = 1 leaves byte i of the word unwritten.
- app_rdy  out  1  command accepted when app_en & app_rdy.
- app_wdf_rdy  out  1  data accepted when app_wdf_wren & app_wdf_rdy.
- app_rd_data  out  256  read data.
- app_rd_data_valid  out  1  app_rd_data is valid this cycle.
- app_rd_data_end  out  1  always equal to app_rd_data_valid.
- init_calib_complete  out  1  high once calibration delay has elapsed.

## Operation
- States:
  - CALIB: counter runs to CALIB_CYCLES, then goes to RUN.
  - RUN: normal operation.
  - WAIT_WDATA: write command held; leaves to RUN on data arrival.
- Write data FIFO: 4 entries × (256 data + 32 mask). app_wdf_rdy = RUN|WAIT_WDATA and FIFO count < 4.
- Write command accepted in RUN:
  - If the FIFO is non-empty, the head entry commits to array[index] at the accept edge.
  - Else, if wren is high in the same cycle, that data bypasses the FIFO and commits.
  - Else, the address is latched and the state goes to WAIT_WDATA. The next accepted wren commits the write and the state returns to RUN.
- app_rdy = (state == RUN) & ~stall (see Configuration). It is a function of registered state only, with no combinational path from app_en.
- Read command accepted: array[index] is sampled at the accept edge into a RD_LATENCY-deep valid/data shift pipeline. Returns are in order, one per accepted read.
- Ordering:
  - A write committed at edge N is visible to any read accepted at edge N+1 or later.
  - Reads cannot be accepted in WAIT_WDATA because app_rdy = 0 there.
- Masked bytes keep their prior contents. Mask 32'hFFFFFFFF makes the write a no-op.
- Address wrap: index bits above DEPTH_LOG2+2 are dropped, so address 8·2^DEPTH_LOG2 aliases word 0.

## Timing
- Reset values: app_rdy 0, app_wdf_rdy 0, app_rd_data_valid 0, app_rd_data_end 0, app_rd_data 0, init_calib_complete 0.
- Reset clears the FIFO, pipeline and state (which returns to CALIB). Array contents are not cleared.
- init_calib_complete rises CALIB_CYCLES edges after synchronized reset release. app_rdy and app_wdf_rdy may rise on the same edge.
- Read latency: command accepted at edge N gives app_rd_data_valid high for exactly one cycle after edge N+RD_LATENCY.
- Throughput: one command per cycle; with back-to-back reads, valid returns are also back-to-back.
- FIFO full (4 entries): app_wdf_rdy = 0. A simultaneous pop by a write command plus a push by wren leaves the count unchanged, and the FIFO still accepts data that cycle only if count < 4 before the edge.
- Reset during in-flight reads: pending returns are discarded and no valid pulse is produced after reset.
- Ignored cmd codes still consume an app_rdy cycle and do not pop the FIFO.

## Configuration
- MIG_RESP_STALL_EN defined:
  - A free-running 3-bit counter, active in RUN, forces app_rdy low on one cycle of every 8 (counter == 7). This models refresh back-pressure.
  - app_wdf_rdy additionally drops on the same cycle.
- Undefined: no stalls; app_rdy is continuously high in RUN.

## Test plan
- Calibration: release sys_rst with CALIB_CYCLES=64 → init_calib_complete, app_rdy and app_wdf_rdy are all 0 for 64 cycles, then 1.
- Same-cycle write/read-back: write cmd at addr 0x00 with wren and data 256'h2 in the same cycle, then read addr 0x00 next cycle → app_rd_data=256'h2, valid exactly 8 cycles after the read accept.
- Data-first and command-first writes:
  - Push 4 data words (0x2, 0x4, 0x6, 0x8) with no cmd → app_wdf_rdy drops after the 4th.
  - Then issue 4 writes to addr 0, 8, 16, 24 and read back → 0x2, 0x4, 0x6, 0x8.
  - Write cmd with no data → app_rdy 0 until wren arrives.
- Mask and wrap: write 256'hFF..FF to word 0, then write 0 with mask 32'hFFFFFFFE to addr 8·2^6 → word 0 reads 256'hFF..FF00.
- Stall and reset: with MIG_RESP_STALL_EN, issue 10 back-to-back reads → app_rdy is low one cycle in every 8 and 10 valids return in order. Assert sys_rst mid-stream → outputs go 0 immediately and no stale valid appears afterwards.

Source files
------------

// File: rtl/mig_ui_responder.sv
// On-chip stand-in for the DDR3 MIG user-interface port: 256-bit array, write-data FIFO, fixed read latency.
// Optional refresh back-pressure model enabled by defining MIG_RESP_STALL_EN.
package mig_ui_responder_pkg;
  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  mask;
  } wdf_entry_t;
endpackage

module mig_ui_responder
  import mig_ui_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2   = 6,
  parameter int unsigned RD_LATENCY   = 8,
  parameter int unsigned CALIB_CYCLES = 64
) (
  input  logic         ui_clk,
  input  logic         sys_rst,
  input  logic [28:0]  app_addr,
  input  logic [2:0]   app_cmd,
  input  logic         app_en,
  input  logic [255:0] app_wdf_data,
  input  logic         app_wdf_wren,
  input  logic         app_wdf_end,
  input  logic [31:0]  app_wdf_mask,
  output logic         app_rdy,
  output logic         app_wdf_rdy,
  output logic [255:0] app_rd_data,
  output logic         app_rd_data_valid,
  output logic         app_rd_data_end,
  output logic         init_calib_complete
);

  localparam int unsigned DATA_W     = 256;
  localparam int unsigned MASK_W     = 32;
  localparam int unsigned ADDR_W     = 29;
  localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PTR_W      = 2;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned CAL_W      = 16;
  localparam logic [2:0]  CMD_WRITE  = 3'b000;
  localparam logic [2:0]  CMD_READ   = 3'b001;

  typedef enum logic [1:0] {
    CALIB      = 2'd0,
    RUN        = 2'd1,
    WAIT_WDATA = 2'd2
  } state_t;

  // Reset: asynchronous assert, deassert synchronized to ui_clk
  logic [1:0] rst_sync;
  logic       ui_clk_sync_rst_n;

  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign ui_clk_sync_rst_n = rst_sync[1];

  state_t                     state, state_nxt;
  logic [CAL_W-1:0]           calib_cnt, calib_cnt_nxt;
  logic [DEPTH_LOG2-1:0]      wait_idx, wait_idx_nxt;
  logic [DEPTH_LOG2-1:0]      cmd_idx;
  logic [DEPTH_LOG2-1:0]      mem_idx;
  logic [DATA_W-1:0]          mem [DEPTH];
  wdf_entry_t                 wdf_fifo [FIFO_DEPTH];
  wdf_entry_t                 mem_wr;
  wdf_entry_t                 wdf_in;
  logic [PTR_W-1:0]           wr_ptr, rd_ptr;
  logic [CNT_W-1:0]           fifo_cnt, fifo_cnt_nxt;
  logic                       fifo_push, fifo_pop, mem_we, rd_issue;
  logic                       cmd_acc, wdf_acc, stall_nxt;
  logic [RD_LATENCY-1:0]              rd_vld_pipe;
  logic [RD_LATENCY-1:0][DATA_W-1:0]  rd_data_pipe;
  logic [DATA_W-1:0]                  rd_data_in;
  logic                               unused_ok;

  assign cmd_idx  = app_addr[DEPTH_LOG2+2:3];
  assign cmd_acc  = app_en & app_rdy;
  assign wdf_acc  = app_wdf_wren & app_wdf_rdy;
  assign wdf_in   = '{data: app_wdf_data, mask: app_wdf_mask};
  assign unused_ok = ^{app_addr[ADDR_W-1:DEPTH_LOG2+3], app_addr[2:0], app_wdf_end};

  // Next-state, FIFO control and array write selection
  always_comb begin
    state_nxt     = state;
    calib_cnt_nxt = calib_cnt;
    wait_idx_nxt  = wait_idx;
    fifo_push     = 1'b0;
    fifo_pop      = 1'b0;
    mem_we        = 1'b0;
    mem_idx       = cmd_idx;
    mem_wr        = wdf_in;
    rd_issue      = 1'b0;
    unique case (state)
      CALIB: begin
        if (calib_cnt == CAL_W'(CALIB_CYCLES - 1)) state_nxt = RUN;
        else calib_cnt_nxt = calib_cnt + CAL_W'(1);
      end
      RUN: begin
        fifo_push = wdf_acc;
        rd_issue  = cmd_acc && (app_cmd == CMD_READ);
        if (cmd_acc && (app_cmd == CMD_WRITE)) begin
          if (fifo_cnt != '0) begin
            fifo_pop = 1'b1;
            mem_we   = 1'b1;
            mem_wr   = wdf_fifo[rd_ptr];
          end else if (wdf_acc) begin
            fifo_push = 1'b0;
            mem_we    = 1'b1;
          end else begin
            wait_idx_nxt = cmd_idx;
            state_nxt    = WAIT_WDATA;
          end
        end
      end
      WAIT_WDATA: begin
        if (wdf_acc) begin
          mem_we    = 1'b1;
          mem_idx   = wait_idx;
          state_nxt = RUN;
        end
      end
      default: state_nxt = CALIB;
    endcase
  end

  assign fifo_cnt_nxt = fifo_cnt + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
  assign rd_data_in   = rd_issue ? mem[cmd_idx] : '0;

`ifdef MIG_RESP_STALL_EN
  // Refresh model: one blocked cycle in every eight once calibrated
  logic [2:0] stall_cnt, stall_cnt_nxt;
  assign stall_cnt_nxt = (state == CALIB) ? stall_cnt : stall_cnt + 3'd1;
  assign stall_nxt     = (stall_cnt_nxt == 3'd7);

  always_ff @(posedge ui_clk or negedge ui_clk_sync_rst_n) begin
    if (!ui_clk_sync_rst_n) stall_cnt <= '0;
    else                    stall_cnt <= stall_cnt_nxt;
  end
`else
  assign stall_nxt = 1'b0;
`endif

  // State, FIFO pointers and registered handshake outputs
  always_ff @(posedge ui_clk or negedge ui_clk_sync_rst_n) begin
    if (!ui_clk_sync_rst_n) begin
      state               <= CALIB;
      calib_cnt           <= '0;
      wait_idx            <= '0;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      fifo_cnt            <= '0;
      app_rdy             <= 1'b0;
      app_wdf_rdy         <= 1'b0;
      init_calib_complete <= 1'b0;
    end else begin
      state               <= state_nxt;
      calib_cnt           <= calib_cnt_nxt;
      wait_idx            <= wait_idx_nxt;
      fifo_cnt            <= fifo_cnt_nxt;
      if (fifo_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      app_rdy             <= (state_nxt == RUN) & ~stall_nxt;
      app_wdf_rdy         <= (state_nxt != CALIB) & (fifo_cnt_nxt < CNT_W'(FIFO_DEPTH)) & ~stall_nxt;
      init_calib_complete <= (state_nxt != CALIB);
    end
  end

  // Read return pipeline; data is sampled from the array at the accept edge
  always_ff @(posedge ui_clk or negedge ui_clk_sync_rst_n) begin
    if (!ui_clk_sync_rst_n) begin
      rd_vld_pipe       <= '0;
      rd_data_pipe      <= '0;
      app_rd_data       <= '0;
      app_rd_data_valid <= 1'b0;
      app_rd_data_end   <= 1'b0;
    end else begin
      rd_vld_pipe       <= {rd_vld_pipe[RD_LATENCY-2:0], rd_issue};
      rd_data_pipe      <= {rd_data_pipe[RD_LATENCY-2:0], rd_data_in};
      app_rd_data       <= rd_data_pipe[RD_LATENCY-1];
      app_rd_data_valid <= rd_vld_pipe[RD_LATENCY-1];
      app_rd_data_end   <= rd_vld_pipe[RD_LATENCY-1];
    end
  end

  // Storage: array and FIFO payloads survive reset
  always_ff @(posedge ui_clk) begin
    if (fifo_push) wdf_fifo[wr_ptr] <= wdf_in;
    if (mem_we) begin
      for (int b = 0; b < int'(MASK_W); b++) begin
        if (!mem_wr.mask[b]) mem[mem_idx][b*8 +: 8] <= mem_wr.data[b*8 +: 8];
      end
    end
  end

endmodule
